// File: rtl/cache_lookup_ctrl.sv
// Cache lookup sequencer: owns the tag/valid/dirty store, detects hits and
// services misses with an optional victim writeback followed by a line fill.
module cache_lookup_ctrl #(
  parameter int ADDR_W   = 64,
  parameter int OFFSET_W = 6,
  parameter int CAP_W    = 14,
  parameter int ASSOC_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_write,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [ASSOC_W-1:0] resp_way,
  output logic               mem_valid,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
);

  localparam int INDEX_W = CAP_W - ASSOC_W - OFFSET_W;
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS    = 1 << INDEX_W;
  localparam int WAYS    = 1 << ASSOC_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    WRITEBACK = 3'd2,
    FILL      = 3'd3,
    RESPOND   = 3'd4
  } state_t;

  state_t state;

  logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
  logic [WAYS-1:0]    valid_mem [SETS];
  logic [WAYS-1:0]    dirty_mem [SETS];
  logic [ASSOC_W-1:0] ptr_mem   [SETS];

  logic [TAG_W-1:0]   cur_tag;
  logic [INDEX_W-1:0] cur_index;
  logic               cur_write;
  logic [ASSOC_W-1:0] sel_way;
  logic               sel_hit;

  logic [WAYS-1:0]    match;
  logic               hit;
  logic [ASSOC_W-1:0] hit_way;
  logic               all_valid;
  logic [ASSOC_W-1:0] victim_way;
  logic               unused_byte_select;

  // The byte select only picks bytes inside the line; it never affects lookup.
  assign unused_byte_select = ^req_addr[OFFSET_W-1:0];

  // Tag compare across the latched set and victim choice (lowest invalid way,
  // otherwise the set's round-robin pointer).
  always_comb begin
    match      = '0;
    hit        = 1'b0;
    hit_way    = '0;
    all_valid  = 1'b1;
    victim_way = ptr_mem[cur_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[w]   = valid_mem[cur_index][w] && (tag_mem[cur_index][w] == cur_tag);
      hit        = hit | match[w];
      hit_way    = match[w] ? ASSOC_W'(w) : hit_way;
      all_valid  = all_valid & valid_mem[cur_index][w];
      victim_way = valid_mem[cur_index][w] ? victim_way : ASSOC_W'(w);
    end
  end

  // Controller FSM with registered outputs, counters and tag-store updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_way   <= '0;
      mem_valid  <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
      cur_tag    <= '0;
      cur_index  <= '0;
      cur_write  <= 1'b0;
      sel_way    <= '0;
      sel_hit    <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        ptr_mem[s]   <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_mem[s][w] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid && req_ready) begin
            cur_tag   <= req_addr[ADDR_W-1:OFFSET_W+INDEX_W];
            cur_index <= req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
            cur_write <= req_write;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end else begin
            req_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (cur_write) begin
              dirty_mem[cur_index][hit_way] <= 1'b1;
            end else begin
              dirty_mem[cur_index][hit_way] <= dirty_mem[cur_index][hit_way];
            end
            hit_count <= (hit_count == 32'hFFFF_FFFF) ? hit_count : hit_count + 32'd1;
            sel_hit   <= 1'b1;
            sel_way   <= hit_way;
            state     <= RESPOND;
          end else begin
            miss_count <= (miss_count == 32'hFFFF_FFFF) ? miss_count : miss_count + 32'd1;
            sel_hit    <= 1'b0;
            sel_way    <= victim_way;
            // The pointer only moves when it actually chose the victim.
            if (all_valid) begin
              ptr_mem[cur_index] <= ptr_mem[cur_index] + ASSOC_W'(1);
            end else begin
              ptr_mem[cur_index] <= ptr_mem[cur_index];
            end
            mem_valid <= 1'b1;
            if (valid_mem[cur_index][victim_way] && dirty_mem[cur_index][victim_way]) begin
              mem_write <= 1'b1;
              mem_addr  <= {tag_mem[cur_index][victim_way], cur_index, {OFFSET_W{1'b0}}};
              state     <= WRITEBACK;
            end else begin
              mem_write <= 1'b0;
              mem_addr  <= {cur_tag, cur_index, {OFFSET_W{1'b0}}};
              state     <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack && mem_valid) begin
            mem_write <= 1'b0;
            mem_addr  <= {cur_tag, cur_index, {OFFSET_W{1'b0}}};
            state     <= FILL;
          end else begin
            state <= WRITEBACK;
          end
        end
        FILL: begin
          if (mem_ack && mem_valid) begin
            tag_mem[cur_index][sel_way]   <= cur_tag;
            valid_mem[cur_index][sel_way] <= 1'b1;
            dirty_mem[cur_index][sel_way] <= cur_write;
            mem_valid                     <= 1'b0;
            state                         <= RESPOND;
          end else begin
            state <= FILL;
          end
        end
        RESPOND: begin
          resp_valid <= 1'b1;
          resp_hit   <= sel_hit;
          resp_way   <= sel_way;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Scoreboard bench for cache_lookup_ctrl: directed accesses push expected
// responses and memory transactions; monitor processes pop and compare.
module tb_cache_lookup_ctrl;

  typedef struct {
    logic        hit;
    logic [2:0]  way;
    bit          chk_lat;
    int          exp_cyc;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
  } mem_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_write;
  logic        resp_valid;
  logic        resp_hit;
  logic [2:0]  resp_way;
  logic        mem_valid;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic        resp_ack;
  logic        stray_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    resp_seen = 0;
  int    accept_cyc = 0;
  int    last_mem_cyc = 0;
  int    ack_delay = 3;
  resp_t resp_q[$];
  mem_t  mem_q[$];

  assign mem_ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  cache_lookup_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .mem_valid  (mem_valid),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        resp_seen++;
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got hit=%0b way=%0d expected none", resp_hit, resp_way);
        end else begin
          r = resp_q.pop_front();
          check("resp_hit", 64'(resp_hit), 64'(r.hit));
          check("resp_way", 64'(resp_way), 64'(r.way));
          if (r.chk_lat) check("hit_latency", 64'(cyc), 64'(r.exp_cyc));
        end
      end
    end
  end

  // Memory responder: checks each line transaction, then acks after ack_delay
  initial begin
    mem_t        m;
    logic        cap_w;
    logic [63:0] cap_a;
    bit          stable;
    bit          aborted;
    resp_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_valid) begin
        last_mem_cyc = cyc;
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem: got write=%0b addr=%0h expected none", mem_write, mem_addr);
        end else begin
          m = mem_q.pop_front();
          check("mem_write", 64'(mem_write), 64'(m.wr));
          check("mem_addr", mem_addr, m.addr);
        end
        cap_w   = mem_write;
        cap_a   = mem_addr;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int i = 1; i < ack_delay; i++) begin
          @(negedge clk);
          if (!mem_valid) begin
            aborted = 1'b1;
            break;
          end
          if (mem_write !== cap_w || mem_addr !== cap_a) stable = 1'b0;
        end
        if (!aborted) begin
          check("mem_stable", 64'(stable), 64'd1);
          resp_ack = 1'b1;
          @(negedge clk);
          resp_ack = 1'b0;
        end
      end
    end
  end

  task automatic access(input logic [63:0] addr, input logic wr, input logic exp_hit,
                        input logic [2:0] exp_way, input bit wait_resp);
    int    n;
    int    seen0;
    resp_t r;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_issue", 64'(req_ready), 64'd1);
    req_addr  = addr;
    req_write = wr;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    accept_cyc = cyc;
    if (wait_resp) begin
      r.hit     = exp_hit;
      r.way     = exp_way;
      r.chk_lat = exp_hit;
      r.exp_cyc = cyc + 2;
      resp_q.push_back(r);
      seen0 = resp_seen;
      n     = 0;
      while (resp_seen == seen0 && n < 300) begin
        @(posedge clk);
        n++;
      end
      if (resp_seen == seen0) begin
        checks++;
        errors++;
        $display("FAIL resp_timeout: got no response for addr %0h expected one", addr);
      end
      @(negedge clk);
    end
  endtask

  task automatic miss(input logic [63:0] addr, input logic wr, input logic [2:0] way);
    mem_q.push_back('{wr: 1'b0, addr: addr & ~64'h3F});
    access(addr, wr, 1'b0, way, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [63:0] set1(input int t);
    return (64'(t) << 11) | 64'h40;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 64'd0;
    req_write = 1'b0;
    stray_ack = 1'b0;

    // Reset values and first ready
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_hit_count", 64'(hit_count), 64'd0);
    check("rst_miss_count", 64'(miss_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(req_ready), 64'd1);

    // Stray mem_ack in IDLE
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ready", 64'(req_ready), 64'd1);
    check("stray_mem_valid", 64'(mem_valid), 64'd0);
    check("stray_miss_count", 64'(miss_count), 64'd0);
    check("stray_hit_count", 64'(hit_count), 64'd0);

    // Cold miss then repeat hit
    miss(64'h1040, 1'b0, 3'd0);
    check("mem_valid_latency", 64'(last_mem_cyc - accept_cyc), 64'd1);
    check("cold_miss_count", 64'(miss_count), 64'd1);
    access(64'h1047, 1'b0, 1'b1, 3'd0, 1'b1);
    check("repeat_hit_count", 64'(hit_count), 64'd1);

    // Fill set 1, then round-robin replacement
    for (int t = 3; t <= 9; t++) miss(set1(t), 1'b0, 3'(t - 2));
    miss(set1(10), 1'b0, 3'd0);
    miss(set1(11), 1'b0, 3'd1);
    access(set1(10), 1'b0, 1'b1, 3'd0, 1'b1);
    miss(set1(2), 1'b0, 3'd2);
    check("repl_miss_count", 64'(miss_count), 64'd11);
    check("repl_hit_count", 64'(hit_count), 64'd2);

    // Dirty victims: via write miss and via write hit
    do_reset();
    check("dirty_start_miss_count", 64'(miss_count), 64'd0);
    miss(64'h1040, 1'b1, 3'd0);
    miss(set1(3), 1'b0, 3'd1);
    access(set1(3) | 64'h8, 1'b1, 1'b1, 3'd1, 1'b1);
    for (int t = 4; t <= 9; t++) miss(set1(t), 1'b0, 3'(t - 2));
    mem_q.push_back('{wr: 1'b1, addr: 64'h1040});
    miss(64'h5040, 1'b0, 3'd0);
    mem_q.push_back('{wr: 1'b1, addr: 64'h1840});
    miss(set1(11), 1'b0, 3'd1);
    check("dirty_miss_count", 64'(miss_count), 64'd10);
    check("dirty_hit_count", 64'(hit_count), 64'd1);

    // Reset in the middle of a fill
    do_reset();
    miss(64'h1040, 1'b0, 3'd0);
    ack_delay = 20;
    mem_q.push_back('{wr: 1'b0, addr: 64'h2040});
    access(64'h2040, 1'b0, 1'b0, 3'd1, 1'b0);
    n = 0;
    while (!mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midfill_mem_valid_before", 64'(mem_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midfill_mem_valid_async", 64'(mem_valid), 64'd0);
    check("midfill_ready_in_rst", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 3;
    @(negedge clk);
    check("midfill_ready_after", 64'(req_ready), 64'd1);
    check("midfill_miss_count", 64'(miss_count), 64'd0);
    miss(64'h1040, 1'b0, 3'd0);
    check("after_rst_miss_count", 64'(miss_count), 64'd1);

    repeat (3) @(negedge clk);
    check("resp_q_empty", 64'(resp_q.size()), 64'd0);
    check("mem_q_empty", 64'(mem_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
